// File: rtl/alu_issue_ctrl_pkg.sv
// Shared encodings for the M0 execute-stage ALU issue controller.
package alu_issue_ctrl_pkg;

    // Data-processing opcode encodings (op unit index)
    localparam logic [3:0] OPC_AND = 4'd0;
    localparam logic [3:0] OPC_EOR = 4'd1;
    localparam logic [3:0] OPC_LSL = 4'd2;
    localparam logic [3:0] OPC_LSR = 4'd3;
    localparam logic [3:0] OPC_ASR = 4'd4;
    localparam logic [3:0] OPC_ADC = 4'd5;
    localparam logic [3:0] OPC_SBC = 4'd6;
    localparam logic [3:0] OPC_ROR = 4'd7;
    localparam logic [3:0] OPC_TST = 4'd8;
    localparam logic [3:0] OPC_NEG = 4'd9;
    localparam logic [3:0] OPC_CMP = 4'd10;
    localparam logic [3:0] OPC_CMN = 4'd11;
    localparam logic [3:0] OPC_ORR = 4'd12;
    localparam logic [3:0] OPC_MUL = 4'd13;
    localparam logic [3:0] OPC_BIC = 4'd14;
    localparam logic [3:0] OPC_MVN = 4'd15;

    // Issue FSM states
    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StIssue = 2'd1,
        StWait  = 2'd2,
        StWb    = 2'd3
    } state_e;

endpackage

// File: rtl/apsr_flag_reg.sv
// Architectural N/Z/C flag register, packed as {C,Z,N}.
module apsr_flag_reg (
    input  logic       clk,
    input  logic       rst,
    input  logic       load,
    input  logic [2:0] d,
    output logic [2:0] q
);

    logic [2:0] flags_q, flags_d;

    // Next value: take the op unit flags only when loaded
    always_comb begin
        flags_d = flags_q;
        if (load) flags_d = d;
    end

    // Flag storage, cleared asynchronously
    always_ff @(posedge clk or posedge rst) begin
        if (rst) flags_q <= 3'b000;
        else     flags_q <= flags_d;
    end

    assign q = flags_q;

endmodule

// File: rtl/alu_issue_ctrl.sv
// Issue controller: accepts one ALU request, enables its op unit for the op
// latency, captures result/flags and hands the result to writeback.
module alu_issue_ctrl
    import alu_issue_ctrl_pkg::*;
#(
    parameter int unsigned NUM_OPS   = 16,
    parameter logic [3:0]  MULTI_OP  = OPC_MUL,
    parameter int unsigned MULTI_LAT = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   flush,
    input  logic                   req_valid,
    output logic                   req_ready,
    input  logic [3:0]             req_opcode,
    input  logic                   req_s,
    input  logic [3:0]             req_rd,
    output logic [NUM_OPS-1:0]     op_en,
    output logic                   op_s,
    input  logic [NUM_OPS*32-1:0]  op_result,
    input  logic [NUM_OPS*3-1:0]   op_flags,
    output logic                   flag_c,
    output logic                   flag_z,
    output logic                   flag_n,
    output logic                   wb_valid,
    input  logic                   wb_ready,
    output logic [31:0]            wb_data,
    output logic [3:0]             wb_rd,
    output logic                   wb_err
);

    // Counter holds MULTI_LAT-2 down to 0; the ISSUE cycle is the first enabled cycle
    localparam int unsigned CntW = (MULTI_LAT > 2) ? $clog2(MULTI_LAT - 1) : 1;

    state_e            state_q, state_d;
    logic [3:0]        opc_q, opc_d;
    logic              s_q, s_d;
    logic [3:0]        rd_q, rd_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic [31:0]       wb_data_q, wb_data_d;
    logic              wb_err_q, wb_err_d;

    logic [NUM_OPS-1:0] opc_onehot;
    logic [31:0]        sel_result;
    logic [2:0]         sel_flags;
    logic [2:0]         flags_q;
    logic               accept, illegal, issuing, capture, flag_load;

    assign illegal   = 32'(req_opcode) >= NUM_OPS;
    assign issuing   = (state_q == StIssue) || (state_q == StWait);
    assign accept    = req_valid && req_ready;
    assign capture   = !flush && (((state_q == StIssue) && (opc_q != MULTI_OP)) ||
                                  ((state_q == StWait) && (cnt_q == '0)));
    assign flag_load = capture && s_q;

    // Decode latched opcode and mux out the matching op unit's result and flags
    always_comb begin
        opc_onehot = '0;
        sel_result = '0;
        sel_flags  = '0;
        for (int i = 0; i < int'(NUM_OPS); i++) begin
            if (opc_q == 4'(i)) begin
                opc_onehot[i] = 1'b1;
                sel_result    = op_result[32*i +: 32];
                sel_flags     = op_flags[3*i +: 3];
            end
        end
    end

    // FSM state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= StIdle;
        else     state_q <= state_d;
    end

    // FSM next state; flush overrides every transition
    always_comb begin
        state_d = state_q;
        if (flush) begin
            state_d = StIdle;
        end else begin
            unique case (state_q)
                StIdle:  if (accept) state_d = illegal ? StWb : StIssue;
                StIssue: state_d = (opc_q == MULTI_OP) ? StWait : StWb;
                StWait:  if (cnt_q == '0) state_d = StWb;
                StWb:    if (wb_ready) state_d = StIdle;
                default: state_d = StIdle;
            endcase
        end
    end

    // FSM outputs
    always_comb begin
        req_ready = (state_q == StIdle) && !flush;
        op_en     = issuing ? opc_onehot : '0;
        op_s      = issuing && s_q;
        wb_valid  = (state_q == StWb);
    end

    // Request latch, latency counter and writeback capture
    always_comb begin
        opc_d     = opc_q;
        s_d       = s_q;
        rd_d      = rd_q;
        cnt_d     = cnt_q;
        wb_data_d = wb_data_q;
        wb_err_d  = wb_err_q;
        if (accept) begin
            opc_d = req_opcode;
            s_d   = req_s;
            rd_d  = req_rd;
            if (illegal) begin
                wb_data_d = '0;
                wb_err_d  = 1'b1;
            end
        end
        if (!flush && (state_q == StIssue) && (opc_q == MULTI_OP)) begin
            cnt_d = CntW'(MULTI_LAT - 2);
        end else if (!flush && (state_q == StWait) && (cnt_q != '0)) begin
            cnt_d = cnt_q - 1'b1;
        end
        if (capture) begin
            wb_data_d = sel_result;
            wb_err_d  = 1'b0;
        end
    end

    // Datapath registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            opc_q     <= '0;
            s_q       <= 1'b0;
            rd_q      <= '0;
            cnt_q     <= '0;
            wb_data_q <= '0;
            wb_err_q  <= 1'b0;
        end else begin
            opc_q     <= opc_d;
            s_q       <= s_d;
            rd_q      <= rd_d;
            cnt_q     <= cnt_d;
            wb_data_q <= wb_data_d;
            wb_err_q  <= wb_err_d;
        end
    end

    apsr_flag_reg u_flags (
        .clk  (clk),
        .rst  (rst),
        .load (flag_load),
        .d    (sel_flags),
        .q    (flags_q)
    );

    assign {flag_c, flag_z, flag_n} = flags_q;
    assign wb_data = wb_data_q;
    assign wb_rd   = rd_q;
    assign wb_err  = wb_err_q;

endmodule
